// File: rtl/axis_protocol_monitor.sv
// axis_protocol_monitor: passive AXI-Stream checker with sticky error flags, saturating
// statistics counters and a packet-tracking FSM; never drives the monitored link.
module axis_protocol_monitor #(
  parameter int DATA_W        = 64,
  parameter int TIMEOUT       = 100,
  parameter int TIMEOUT_W     = 8,
  parameter int MAX_PKT_BEATS = 256,
  parameter int CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    tdata,
  input  logic                 tvalid,
  input  logic                 tready,
  input  logic                 tlast,
  input  logic                 clear,
  output logic [5:0]           err_flags,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_count,
  output logic [CNT_W-1:0]     beat_count,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [TIMEOUT_W-1:0] stall_cycles,
  output logic                 in_packet
);
  localparam int PB_W = $clog2(MAX_PKT_BEATS + 2);
  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT - 1);
  localparam logic [PB_W-1:0] PB_LIM = PB_W'(MAX_PKT_BEATS == 0 ? 0 : MAX_PKT_BEATS - 1);
  typedef enum logic {IDLE, IN_PKT} state_t;
  state_t state;
  logic pend, hold_last, hs, st, any_err;
  logic [DATA_W-1:0] hold_data;
  logic [PB_W-1:0] pkt_beats;
  logic [5:0] viol;
  always_comb begin
    hs = tvalid && tready;
    st = tvalid && !tready;
    viol[0] = pend && !tvalid;
    viol[1] = pend && tvalid && (tdata != hold_data);
    viol[2] = pend && tvalid && (tlast != hold_last);
    viol[3] = tlast && !tvalid;
    viol[4] = st && (stall_cycles == TO_LIM);
    viol[5] = (MAX_PKT_BEATS != 0) && hs && !tlast && (pkt_beats == PB_LIM);
    any_err = |viol;
  end
  // clear only zeroes the old value; an event in the same cycle still lands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pend         <= 1'b0;
      hold_data    <= '0;
      hold_last    <= 1'b0;
      pkt_beats    <= '0;
      stall_cycles <= '0;
      err_flags    <= '0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
      beat_count   <= '0;
      pkt_count    <= '0;
      in_packet    <= 1'b0;
    end else begin
      pend <= st;
      if (st) begin
        hold_data <= tdata;
        hold_last <= tlast;
      end
      stall_cycles <= st ? stall_cycles + TIMEOUT_W'(stall_cycles != '1) : '0;
      err_flags    <= (clear ? 6'b0 : err_flags) | viol;
      err_pulse    <= any_err;
      err_count    <= clear ? CNT_W'(any_err) : err_count + CNT_W'(any_err && err_count != '1);
      beat_count   <= clear ? CNT_W'(hs) : beat_count + CNT_W'(hs && beat_count != '1);
      pkt_count    <= clear ? CNT_W'(hs && tlast) : pkt_count + CNT_W'(hs && tlast && pkt_count != '1);
      if (hs && tlast) begin
        state     <= IDLE;
        in_packet <= 1'b0;
        pkt_beats <= '0;
      end else if (hs) begin
        state     <= IN_PKT;
        in_packet <= 1'b1;
        pkt_beats <= (state == IDLE) ? PB_W'(1) : pkt_beats + PB_W'(pkt_beats != '1);
      end
    end
  end
endmodule

// File: doc/axis_protocol_monitor.md
Name: axis_protocol_monitor

Overview:
- Passive, parametrised AXI-Stream protocol checker. It taps any stream link (master->slave) and never drives the bus.
- Replaces per-interface inline checks with synthesizable sticky error flags, counters and a packet-tracking FSM.
- Simulation (Icarus, Verilator) and the on-chip debug register bank can both read the results.
- Generalised over data width, stall timeout and maximum packet length.

Parameters:
DATA_W, 64, width of tdata in bits.
TIMEOUT, 100, backpressure cycles (tvalid&&!tready) that trigger a timeout. Legal range 1..2^TIMEOUT_W-1.
TIMEOUT_W, 8, width of the stall counter.
MAX_PKT_BEATS, 256, maximum beats per packet including the tlast beat. 0 disables the check.
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock; all monitoring is on the rising edge.
rst  in  1  reset, asynchronous, active-high.
tdata  in  DATA_W  monitored payload.
tvalid  in  1  monitored TVALID.
tready  in  1  monitored TREADY.
tlast  in  1  monitored TLAST.
clear  in  1  synchronous clear of flags and counters.
err_flags  out  6  sticky errors: [0] VALID_DROP, [1] DATA_CHANGE, [2] LAST_CHANGE, [3] LAST_NO_VALID, [4] TIMEOUT, [5] PKT_TOO_LONG.
err_pulse  out  1  high for one cycle after any cycle in which a violation was detected.
err_count  out  CNT_W  number of violating cycles, saturating.
beat_count  out  CNT_W  accepted beats (tvalid&&tready), saturating.
pkt_count  out  CNT_W  accepted tlast beats, saturating.
stall_cycles  out  TIMEOUT_W  length of the current backpressure run, saturating.
in_packet  out  1  FSM is in IN_PKT.

Behaviour:
- Reset (async assert) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - pend=0, hold_data=0, hold_last=0, pkt_beats=0.
- Handshake hs = tvalid&&tready. Stall st = tvalid&&!tready.
- Pending tracker, per edge:
  - pend <= st.
  - When st, capture hold_data <= tdata and hold_last <= tlast.
- Checks, all evaluated on the same sampled cycle:
  - VALID_DROP: pend && !tvalid.
  - DATA_CHANGE: pend && tvalid && tdata!=hold_data.
  - LAST_CHANGE: pend && tvalid && tlast!=hold_last.
  - LAST_NO_VALID: tlast && !tvalid.
  - TIMEOUT: st && stall_cycles==TIMEOUT-1. Fires exactly once per stall run.
  - PKT_TOO_LONG: MAX_PKT_BEATS!=0 && hs && !tlast && pkt_beats==MAX_PKT_BEATS-1. Fires once per packet.
- Latency: a violation sampled at edge N shows on err_flags, err_pulse and err_count after edge N.
- err_count increments by exactly 1 per violating cycle, however many checks fire in that cycle.
- stall_cycles:
  - increments while st;
  - saturates at 2^TIMEOUT_W-1;
  - reloads to 0 on any cycle without st.
- FSM:
  - IDLE -hs&&!tlast-> IN_PKT, pkt_beats<=1.
  - IDLE -hs&&tlast-> IDLE (single-beat packet).
  - IN_PKT -hs&&!tlast-> IN_PKT, pkt_beats+1, saturating.
  - IN_PKT -hs&&tlast-> IDLE, pkt_beats<=0.
  - Any other cycle: hold state.
- Counters: beat_count increments on hs; pkt_count increments on hs&&tlast. All counters saturate at all-ones and do not wrap.
- clear:
  - zeroes err_flags, err_count, beat_count and pkt_count.
  - Does not touch FSM, pend, hold registers or stall_cycles.
- clear simultaneous with an event: the event wins. The flag is set and the counter loads 1, not old+1.
- Reset asserted mid-packet or mid-stall: all state is discarded. The first beat after reset release is treated as a packet start.
- No outputs feed back into the monitored link. Pure observer.

Test Plan:
- Clean traffic:
  - Stimulus: 3 packets of 4 beats, tready always 1.
  - Required: beat_count=12, pkt_count=3, err_flags=0, in_packet=0 at the end.
- Backpressure hold:
  - Stimulus: tvalid=1, tdata=0xA5, tready=0 for 5 cycles, then tready=1.
  - Required: no errors, stall_cycles peaks at 5, beat_count=1.
- Stall violation:
  - Stimulus: tdata changes 0xA5->0x5A and tlast toggles during the stall, then tvalid drops before handshake.
  - Required: err_flags=6'b000111, err_count=3, with err_pulse on each violating cycle.
- Timeout (TIMEOUT=100):
  - Stimulus: tvalid=1, tready=0 for 150 cycles.
  - Required: err_flags[4] set one cycle after the 100th stall cycle, err_count=1, stall_cycles=150.
- Long packet (MAX_PKT_BEATS=4):
  - Stimulus: 6-beat packet.
  - Required: err_flags[5] set after beat 4, err_count=1, pkt_count=1.
- clear/reset interplay:
  - Stimulus: clear in the same cycle as tlast&&!tvalid.
  - Required: err_flags=6'b001000, err_count=1.
  - Then: async rst mid-packet clears all outputs immediately; the next 2-beat packet gives pkt_count=1 with no errors.
